// File: rtl/aska_seq_pkg.sv
// Shared types and configuration field positions for the electrode scan sequencer.
package aska_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BREAK   = 2'd1,
    ST_SETTLE  = 2'd2,
    ST_MEASURE = 2'd3
  } state_t;

  localparam int C0_RUN        = 0;
  localparam int C0_SINGLE     = 1;
  localparam int C0_LAST_LSB   = 2;
  localparam int C0_LAST_W     = 3;
  localparam int C0_DWELL_LSB  = 8;
  localparam int C0_DWELL_W    = 8;
  localparam int C1_SETTLE_LSB = 0;
  localparam int C1_SETTLE_W   = 8;

  localparam int ENTRY_W     = 8;
  localparam int SEQ_N_STEPS = 8;

endpackage

// File: rtl/aska_seq_cnt.sv
// Loadable down-counter with zero flag; holds at zero rather than wrapping.
module aska_seq_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (dec && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/aska_ele_seq.sv
// Electrode scan sequencer: walks source/sink pairs with break-before-make,
// settle blanking and a measurement window, snapshotting configuration per frame.
module aska_ele_seq
  import aska_seq_pkg::*;
#(
  parameter int M       = 32,
  parameter int SEL_W   = 4,
  parameter int N_STEPS = SEQ_N_STEPS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [M-1:0]     conf0,
  input  logic [M-1:0]     conf1,
  input  logic [M-1:0]     ele1,
  input  logic [M-1:0]     ele2,
  output logic [SEL_W-1:0] src_sel,
  output logic [SEL_W-1:0] snk_sel,
  output logic             sw_en,
  output logic             meas_valid,
  output logic [2:0]       step_idx,
  output logic             frame_done,
  output logic             busy,
  output logic             err
);

  state_t                 state_reg;
  logic                   run_q_reg;
  logic                   single_reg;
  logic                   err_reg;
  logic [C0_LAST_W-1:0]   last_reg;
  logic [2:0]             step_reg;
  logic [C0_DWELL_W-1:0]  dwell_reg;
  logic [C1_SETTLE_W-1:0] settle_reg;
  logic [SEL_W-1:0]       src_reg;
  logic [SEL_W-1:0]       snk_reg;
  logic [ENTRY_W-1:0]     ent_reg [N_STEPS];
  logic [ENTRY_W-1:0]     in_ent  [N_STEPS];

  logic                   run;
  logic                   single_in;
  logic [C0_LAST_W-1:0]   last_in;
  logic [C0_DWELL_W-1:0]  dwell_in;
  logic [C1_SETTLE_W-1:0] settle_in;
  logic                   unused_bits;

  assign run         = conf0[C0_RUN];
  assign single_in   = conf0[C0_SINGLE];
  assign last_in     = conf0[C0_LAST_LSB +: C0_LAST_W];
  assign dwell_in    = conf0[C0_DWELL_LSB +: C0_DWELL_W];
  assign settle_in   = conf1[C1_SETTLE_LSB +: C1_SETTLE_W];
  assign unused_bits = ^{conf0[M-1:16], conf0[7:5], conf1[M-1:8]};

  genvar gi;
  generate
    for (gi = 0; gi < N_STEPS; gi++) begin : g_ent
      if (gi < 4) begin : g_lo
        assign in_ent[gi] = ele1[ENTRY_W*gi +: ENTRY_W];
      end else begin : g_hi
        assign in_ent[gi] = ele2[ENTRY_W*(gi-4) +: ENTRY_W];
      end
    end
  endgenerate

  logic       pair_bad;
  logic       cnt_zero;
  logic       adv;
  logic       is_last;
  logic       start;
  logic       abort;
  logic       frame_load;
  logic       step_next;
  logic [2:0] next_idx;

  assign pair_bad   = (src_reg == snk_reg);
  assign adv        = ((state_reg == ST_BREAK) && pair_bad) ||
                      ((state_reg == ST_MEASURE) && cnt_zero);
  assign is_last    = (step_reg == last_reg);
  assign start      = run && (!single_in || !run_q_reg);
  assign abort      = (state_reg != ST_IDLE) && !run;
  // A continuous frame rolls straight into the next one, re-snapshotting the config.
  assign frame_load = ((state_reg == ST_IDLE) && start) ||
                      (run && adv && is_last && !single_reg);
  assign step_next  = adv && !is_last;
  assign next_idx   = step_reg + 3'd1;

  logic                   cnt_load;
  logic [C0_DWELL_W-1:0]  cnt_val;

  assign cnt_load = ((state_reg == ST_BREAK) && !pair_bad) ||
                    ((state_reg == ST_SETTLE) && cnt_zero);
  assign cnt_val  = ((state_reg == ST_BREAK) && (settle_reg != 8'd0)) ?
                    (settle_reg - 8'd1) : dwell_reg;

  aska_seq_cnt #(.W(C0_DWELL_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (sw_en),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      run_q_reg  <= 1'b0;
      single_reg <= 1'b0;
      last_reg   <= '0;
      dwell_reg  <= '0;
      settle_reg <= '0;
      step_reg   <= '0;
      src_reg    <= '0;
      snk_reg    <= '0;
      for (int i = 0; i < N_STEPS; i++) ent_reg[i] <= '0;
    end else begin
      run_q_reg <= run;
      if (abort) begin
        state_reg <= ST_IDLE;
      end else if (frame_load) begin
        state_reg  <= ST_BREAK;
        single_reg <= single_in;
        last_reg   <= last_in;
        dwell_reg  <= dwell_in;
        settle_reg <= settle_in;
        for (int i = 0; i < N_STEPS; i++) ent_reg[i] <= in_ent[i];
        step_reg   <= '0;
        src_reg    <= in_ent[0][ENTRY_W-1 -: SEL_W];
        snk_reg    <= in_ent[0][SEL_W-1:0];
      end else if (step_next) begin
        state_reg <= ST_BREAK;
        step_reg  <= next_idx;
        src_reg   <= ent_reg[next_idx][ENTRY_W-1 -: SEL_W];
        snk_reg   <= ent_reg[next_idx][SEL_W-1:0];
      end else if (adv) begin
        state_reg <= ST_IDLE;
      end else begin
        case (state_reg)
          ST_BREAK:  state_reg <= (settle_reg != 8'd0) ? ST_SETTLE : ST_MEASURE;
          ST_SETTLE: if (cnt_zero) state_reg <= ST_MEASURE;
          default:   ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_reg <= 1'b0;
    end else if (abort) begin
      err_reg <= 1'b0;
    end else if ((state_reg == ST_BREAK) && pair_bad) begin
      err_reg <= 1'b1;
    end
  end

  assign src_sel    = src_reg;
  assign snk_sel    = snk_reg;
  assign sw_en      = (state_reg == ST_SETTLE) || (state_reg == ST_MEASURE);
  assign meas_valid = (state_reg == ST_MEASURE);
  assign step_idx   = step_reg;
  assign frame_done = run && adv && is_last;
  assign busy       = (state_reg != ST_IDLE);
  assign err        = err_reg;

endmodule

// File: tb/tb_aska_ele_seq.sv
// Scoreboard bench: expected per-cycle outputs are queued from the scan schedule and compared on negedge.
module tb_aska_ele_seq;

  localparam int BIG = 1000000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] conf0, conf1, ele1, ele2;
  logic [3:0]  src_sel, snk_sel;
  logic        sw_en, meas_valid, frame_done, busy, err;
  logic [2:0]  step_idx;

  always #5 clk = ~clk;

  aska_ele_seq dut (
    .clk        (clk),
    .reset      (reset),
    .conf0      (conf0),
    .conf1      (conf1),
    .ele1       (ele1),
    .ele2       (ele2),
    .src_sel    (src_sel),
    .snk_sel    (snk_sel),
    .sw_en      (sw_en),
    .meas_valid (meas_valid),
    .step_idx   (step_idx),
    .frame_done (frame_done),
    .busy       (busy),
    .err        (err)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          budget;
  logic [15:0] exp_q[$];
  logic [3:0]  m_src, m_snk;
  logic [2:0]  m_step;
  logic        m_err;

  // Packed view: {src, snk, sw_en, meas_valid, step_idx, frame_done, busy, err}
  function automatic logic [15:0] obs();
    return {src_sel, snk_sel, sw_en, meas_valid, step_idx, frame_done, busy, err};
  endfunction

  function automatic logic [31:0] mk_conf0(input logic run, input logic single,
                                           input logic [2:0] last, input logic [7:0] dwell);
    return {16'h0000, dwell, 3'b000, last, single, run};
  endfunction

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h required %h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic push_one(input logic [15:0] v);
    if (budget > 0) begin
      exp_q.push_back(v);
      budget--;
      m_src  = v[15:12];
      m_snk  = v[11:8];
      m_step = v[5:3];
    end
  endtask

  task automatic push_frame(input logic [31:0] e1, input logic [31:0] e2,
                            input int last, input int settle, input int dwell);
    logic [7:0] ent;
    logic [3:0] s, k;
    logic [2:0] st;
    logic       took;
    for (int i = 0; i <= last; i++) begin
      ent = (i < 4) ? e1[8*i +: 8] : e2[8*(i-4) +: 8];
      s   = ent[7:4];
      k   = ent[3:0];
      st  = 3'(i);
      if (s == k) begin
        took = (budget > 0);
        push_one({s, k, 1'b0, 1'b0, st, (i == last), 1'b1, m_err});
        if (took) m_err = 1'b1;
      end else begin
        push_one({s, k, 1'b0, 1'b0, st, 1'b0, 1'b1, m_err});
        for (int c = 0; c < settle; c++) push_one({s, k, 1'b1, 1'b0, st, 1'b0, 1'b1, m_err});
        for (int c = 0; c <= dwell; c++)
          push_one({s, k, 1'b1, 1'b1, st, (i == last) && (c == dwell), 1'b1, m_err});
      end
    end
  endtask

  task automatic push_idle(input int n);
    for (int c = 0; c < n; c++) push_one({m_src, m_snk, 1'b0, 1'b0, m_step, 1'b0, 1'b0, m_err});
  endtask

  task automatic tick();
    logic [15:0] want;
    @(negedge clk);
    cyc++;
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      check_val($sformatf("cyc%0d", cyc), obs(), want);
      if (want[2])
        $display("frame_done cyc %0d step %0d src %0d snk %0d err %0d", cyc, want[5:3], want[15:12], want[11:8], want[0]);
    end
  endtask

  task automatic drain();
    while (exp_q.size() > 0) tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    conf0 = '0; conf1 = '0; ele1 = '0; ele2 = '0;
    m_src = '0; m_snk = '0; m_step = '0; m_err = 1'b0;
    budget = BIG;
    repeat (3) @(negedge clk);
    check_val("reset", obs(), 16'h0000);
    reset = 1'b0;

    // Continuous scan, two steps, 14-cycle frames
    conf0 = mk_conf0(1'b1, 1'b0, 3'd1, 8'd3);
    conf1 = 32'd2;
    ele1  = 32'h0000_2301;
    push_frame(ele1, ele2, 1, 2, 3);
    push_frame(ele1, ele2, 1, 2, 3);
    drain();

    // Rewrite pairs during step 0: current frame keeps the old ones
    push_frame(32'h0000_2301, 32'h0, 1, 2, 3);
    repeat (3) tick();
    ele1 = 32'h0000_4567;
    drain();
    push_frame(ele1, ele2, 1, 2, 3);
    drain();

    // Drop run during SETTLE
    budget = 2;
    push_frame(ele1, ele2, 1, 2, 3);
    drain();
    conf0  = '0;
    m_err  = 1'b0;
    budget = BIG;
    push_idle(2);
    drain();

    // Single-shot: one frame, no restart until run toggles
    conf0 = mk_conf0(1'b1, 1'b1, 3'd1, 8'd3);
    ele1  = 32'h0000_2301;
    push_frame(ele1, ele2, 1, 2, 3);
    push_idle(4);
    drain();
    conf0 = mk_conf0(1'b0, 1'b1, 3'd1, 8'd3);
    push_idle(1);
    drain();
    conf0 = mk_conf0(1'b1, 1'b1, 3'd1, 8'd3);
    push_frame(ele1, ele2, 1, 2, 3);
    push_idle(3);
    drain();

    // settle=0, dwell=0, all eight steps
    conf0 = mk_conf0(1'b1, 1'b0, 3'd7, 8'd0);
    conf1 = 32'd0;
    ele1  = 32'h7654_3210;
    ele2  = 32'hFEDC_BA98;
    push_frame(ele1, ele2, 7, 0, 0);
    push_frame(ele1, ele2, 7, 0, 0);
    drain();
    conf0 = '0;
    m_err = 1'b0;
    push_idle(1);
    drain();

    // Single-step frames with maximum dwell
    conf0 = mk_conf0(1'b1, 1'b0, 3'd0, 8'd255);
    ele1  = 32'h0000_00A5;
    ele2  = 32'h0;
    push_frame(ele1, ele2, 0, 0, 255);
    push_frame(ele1, ele2, 0, 0, 255);
    drain();
    conf0 = '0;
    m_err = 1'b0;
    push_idle(1);
    drain();

    // Invalid pair at step 1
    conf0 = mk_conf0(1'b1, 1'b1, 3'd2, 8'd1);
    conf1 = 32'd1;
    ele1  = 32'h0023_5501;
    push_frame(ele1, ele2, 2, 1, 1);
    push_idle(2);
    drain();
    conf0 = mk_conf0(1'b0, 1'b1, 3'd2, 8'd1);
    push_idle(1);
    drain();
    conf0  = mk_conf0(1'b1, 1'b0, 3'd2, 8'd1);
    budget = 4;
    push_frame(ele1, ele2, 2, 1, 1);
    drain();
    budget = BIG;

    // Reset mid-frame with err set
    reset = 1'b1;
    #1;
    check_val("async_reset", obs(), 16'h0000);
    conf0 = '0;
    @(negedge clk);
    check_val("reset_hold", obs(), 16'h0000);
    reset  = 1'b0;
    m_src  = '0; m_snk = '0; m_step = '0; m_err = 1'b0;
    push_idle(2);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
